// File: rtl/apb_reg_completer_if.sv
// APB4 bus bundle between a requester and apb_reg_completer.
// The requester drives select/control/data; the completer returns PRDATA/PREADY/PSLVERR.
interface apb_reg_completer_if;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PNSE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_completer.sv
// APB4 completer with ID/CTRL/STATUS/scratch registers, programmable wait states,
// byte-strobe writes, decoded error responses and requester protocol checking.
module apb_reg_completer #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
    parameter logic [31:0] CTRL_RST    = 32'h0000_0000
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_reg_completer_if.slave  apb,
    input  logic [31:0]         status_in,
    output logic [31:0]         ctrl_out,
    output logic                proto_err
);
    localparam int unsigned IW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e          state_q, state_d, cur_state;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            err_q, err_d;
    logic            write_q, write_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      strb_q, strb_d;
    logic            proto_err_q, proto_err_d;
    logic [31:0]     regs_q [NUM_REGS];
    logic [31:0]     regs_d [NUM_REGS];

    logic [29:0]     word_addr;
    logic            dec_err;
    logic            violation;
    logic            done;
    logic [31:0]     rd_word;

    assign word_addr = apb.PADDR[31:2];

    assign dec_err = (apb.PADDR[1:0] != 2'b00)
                  || (word_addr >= 30'(NUM_REGS))
                  || (apb.PWRITE && (word_addr == 30'd0 || word_addr == 30'd2))
                  || (!apb.PWRITE && apb.PSTRB != 4'h0)
                  || apb.PNSE
                  || (apb.PWRITE && word_addr == 30'd1 && !apb.PPROT[0]);

    // Only IDLE/ACCESS are ever stored: SETUP is the IDLE cycle in which the bus
    // shows a setup phase, so a transfer takes WAIT_STATES+2 cycles with no bubble.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        regs_d      = regs_q;
        violation   = 1'b0;
        done        = 1'b0;
        cur_state   = state_q;
        if (state_q == IDLE && apb.PSELx && !apb.PENABLE) begin
            cur_state = SETUP;
        end

        case (cur_state)
            IDLE: begin
                if (apb.PENABLE) begin
                    violation = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_STATES);
                idx_d   = word_addr[IW-1:0];
                err_d   = dec_err;
                write_d = apb.PWRITE;
                wdata_d = apb.PWDATA;
                strb_d  = apb.PSTRB;
            end
            ACCESS: begin
                if (!apb.PSELx || !apb.PENABLE) begin
                    violation = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                    if (write_q && !err_q) begin
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (strb_q[b]) begin
                                regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        proto_err_d = violation;
    end

    always_comb begin
        rd_word = regs_q[idx_q];
        if (idx_q == IW'(0)) begin
            rd_word = ID_VALUE;
        end else if (idx_q == IW'(2)) begin
            rd_word = status_in;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            proto_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 1) ? CTRL_RST : '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            proto_err_q <= proto_err_d;
            regs_q      <= regs_d;
        end
    end

    assign apb.PREADY  = done;
    assign apb.PSLVERR = done && err_q;
    assign apb.PRDATA  = (done && !err_q && !write_q) ? rd_word : '0;
    assign ctrl_out    = regs_q[1];
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench: three completers (WAIT_STATES 1, 0, 3) share one requester bus;
// only the selected one sees PSELx/PENABLE, and a monitor checks each PREADY response.
module tb_apb_reg_completer;
    logic        clk = 1'b0;
    logic        prst;
    logic        psel, penable, pwrite, pnse;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] status_word = 32'h5A5A_0F0F;
    logic [1:0]  sel;

    logic        cur_ready, cur_err, cur_perr;
    logic [31:0] cur_rd, cur_ctrl;
    logic [31:0] ctrl_a [3];
    logic        perr_a [3];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    apb_reg_completer_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].PSELx   = psel && (sel == 2'(g));
        assign bus[g].PENABLE = penable && (sel == 2'(g));
        assign bus[g].PADDR   = paddr;
        assign bus[g].PWRITE  = pwrite;
        assign bus[g].PWDATA  = pwdata;
        assign bus[g].PSTRB   = pstrb;
        assign bus[g].PPROT   = pprot;
        assign bus[g].PNSE    = pnse;

        apb_reg_completer #(
            .NUM_REGS    (8),
            .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .ID_VALUE    (32'hA5B0_0001),
            .CTRL_RST    (32'h0000_0000)
        ) dut (
            .PCLK      (clk),
            .PRESET    (prst),
            .apb       (bus[g]),
            .status_in (status_word),
            .ctrl_out  (ctrl_a[g]),
            .proto_err (perr_a[g])
        );
    end

    always_comb begin
        case (sel)
            2'd1: begin
                cur_ready = bus[1].PREADY; cur_err = bus[1].PSLVERR; cur_rd = bus[1].PRDATA;
                cur_ctrl = ctrl_a[1]; cur_perr = perr_a[1];
            end
            2'd2: begin
                cur_ready = bus[2].PREADY; cur_err = bus[2].PSLVERR; cur_rd = bus[2].PRDATA;
                cur_ctrl = ctrl_a[2]; cur_perr = perr_a[2];
            end
            default: begin
                cur_ready = bus[0].PREADY; cur_err = bus[0].PSLVERR; cur_rd = bus[0].PRDATA;
                cur_ctrl = ctrl_a[0]; cur_perr = perr_a[0];
            end
        endcase
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic int unsigned ws_sel();
        return (sel == 2'd0) ? 1 : ((sel == 2'd1) ? 0 : 3);
    endfunction

    // Monitor: every PREADY must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (cur_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_prdata"}, cur_rd, e.rd);
                chk({e.name, "_pslverr"}, 32'(cur_err), 32'(e.err));
            end
        end
    end

    task automatic xfer(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                        input logic nse, input logic [31:0] exp_rd, input logic exp_err);
        int unsigned n = 0;
        bit got = 1'b0;
        exp_q.push_back('{nm, exp_rd, exp_err});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wd; pstrb = st; pprot = pr; pnse = nse;
        @(posedge clk); #1;
        penable = 1'b1;
        // Address/data/strobes/direction must be taken from the setup cycle.
        paddr = addr ^ 32'h0000_0010; pwdata = ~wd; pstrb = ~st; pwrite = ~wr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cur_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        if (!got) chk({nm, "_pready_timeout"}, 32'd0, 32'd1);
        else      chk({nm, "_wait_cycles"}, n, ws_sel());
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        sel = 2'd0; prst = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pnse = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (2) @(posedge clk);
        #1 prst = 1'b0;
        @(negedge clk);
        chk("rst_pready", 32'(cur_ready), 32'd0);
        chk("rst_prdata", cur_rd, 32'd0);
        chk("rst_pslverr", 32'(cur_err), 32'd0);
        chk("rst_proto_err", 32'(cur_perr), 32'd0);
        chk("rst_ctrl_out", cur_ctrl, 32'd0);
        @(posedge clk); #1;

        // WAIT_STATES=1 completer: register map and error decode
        xfer("rd_id",        1'b0, 32'h00, 32'h0,         4'h0, 3'b000, 1'b0, 32'hA5B0_0001, 1'b0);
        xfer("wr_ctrl",      1'b1, 32'h04, 32'h1234_5678, 4'b0101, 3'b001, 1'b0, 32'h0, 1'b0);
        chk("ctrl_out_after_wr", cur_ctrl, 32'h0034_0078);
        xfer("rd_ctrl",      1'b0, 32'h04, 32'h0,         4'h0, 3'b001, 1'b0, 32'h0034_0078, 1'b0);
        xfer("wr_status",    1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b0, 32'h0, 1'b1);
        xfer("rd_misalign",  1'b0, 32'h06, 32'h0,         4'h0, 3'b000, 1'b0, 32'h0, 1'b1);
        xfer("rd_oor",       1'b0, 32'h20, 32'h0,         4'h0, 3'b000, 1'b0, 32'h0, 1'b1);
        xfer("rd_status",    1'b0, 32'h08, 32'h0,         4'h0, 3'b000, 1'b0, 32'h5A5A_0F0F, 1'b0);
        xfer("wr_id",        1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b0, 32'h0, 1'b1);
        xfer("wr_ctrl_unpriv", 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b0, 32'h0, 1'b1);
        chk("ctrl_out_unpriv", cur_ctrl, 32'h0034_0078);
        xfer("rd_strb",      1'b0, 32'h0C, 32'h0,         4'h1, 3'b000, 1'b0, 32'h0, 1'b1);
        xfer("rd_nse",       1'b0, 32'h04, 32'h0,         4'h0, 3'b001, 1'b1, 32'h0, 1'b1);
        xfer("wr_nse",       1'b1, 32'h0C, 32'h1111_1111, 4'hF, 3'b001, 1'b1, 32'h0, 1'b1);
        xfer("wr_last",      1'b1, 32'h1C, 32'h1122_3344, 4'hF, 3'b000, 1'b0, 32'h0, 1'b0);
        xfer("rd_last",      1'b0, 32'h1C, 32'h0,         4'h0, 3'b000, 1'b0, 32'h1122_3344, 1'b0);
        xfer("wr_strb0",     1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h0, 3'b000, 1'b0, 32'h0, 1'b0);
        xfer("rd_after_strb0", 1'b0, 32'h0C, 32'h0,       4'h0, 3'b000, 1'b0, 32'h0, 1'b0);
        xfer("rd_ctrl_final", 1'b0, 32'h04, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0034_0078, 1'b0);

        // WAIT_STATES=0 completer: back-to-back write then read in 4 cycles
        sel = 2'd1;
        c0 = cyc;
        xfer("b2b_wr", 1'b1, 32'h0C, 32'hDEAD_BEEF, 4'hF, 3'b000, 1'b0, 32'h0, 1'b0);
        xfer("b2b_rd", 1'b0, 32'h0C, 32'h0,         4'h0, 3'b000, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("b2b_cycles", cyc - c0, 32'd4);

        // WAIT_STATES=3 completer: PENABLE dropped mid-ACCESS aborts the write
        sel = 2'd2;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b001; pnse = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 penable = 1'b0;
        @(negedge clk);
        chk("abort_proto_err_before", 32'(cur_perr), 32'd0);
        @(posedge clk); #1 psel = 1'b0;
        @(negedge clk);
        chk("abort_proto_err_pulse", 32'(cur_perr), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_proto_err_clear", 32'(cur_perr), 32'd0);
        @(posedge clk); #1;
        xfer("rd_after_abort", 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0, 1'b0);

        // PENABLE without PSELx while idle
        penable = 1'b1;
        @(posedge clk); #1 penable = 1'b0;
        @(negedge clk);
        chk("idle_penable_proto_err", 32'(cur_perr), 32'd1);
        @(posedge clk); #1;

        // WAIT_STATES=1 completer: reset during ACCESS of a CTRL write
        sel = 2'd0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04;
        pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b001; pnse = 1'b0;
        @(posedge clk); #1 penable = 1'b1; prst = 1'b1;
        @(posedge clk); #1 prst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("midrst_pready", 32'(cur_ready), 32'd0);
        chk("midrst_prdata", cur_rd, 32'd0);
        chk("midrst_pslverr", 32'(cur_err), 32'd0);
        chk("midrst_proto_err", 32'(cur_perr), 32'd0);
        chk("midrst_ctrl_out", cur_ctrl, 32'd0);
        @(posedge clk); #1;
        xfer("rd_last_after_rst", 1'b0, 32'h1C, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_reg_completer.md
# apb_reg_completer

APB4 completer (slave-side endpoint) with a small memory-mapped register bank, programmable wait states, byte-strobe writes and decoded error responses. It is the responder counterpart to the team's APB requester. It attaches directly to the requester's PSELx/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT/PNSE outputs and returns PRDATA/PREADY/PSLVERR. It also exports one control register to the surrounding logic and samples one status word from it.

## Interface
Parameters:
- NUM_REGS, 8, number of 32-bit registers; legal range 4..64.
- WAIT_STATES, 1, wait cycles inserted in ACCESS before PREADY; legal range 0..15.
- ID_VALUE, 32'hA5B0_0001, constant returned by the ID register.
- CTRL_RST, 32'h0000_0000, reset value of the CTRL register.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSELx  in  1  completer select.
- PENABLE  in  1  access phase.
- PADDR  in  32  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte strobes.
- PPROT  in  3  protection attributes.
- PNSE  in  1  non-secure extension.
- status_in  in  32  live status word, readable at STATUS.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- ctrl_out  out  32  current CTRL register value.
- proto_err  out  1  one-cycle pulse on a requester protocol violation.

## Operation
- Register map, word index = PADDR[7:2]:
  - 0x00 ID: read-only, returns ID_VALUE.
  - 0x04 CTRL: read/write; drives ctrl_out.
  - 0x08 STATUS: read-only; returns status_in as sampled in the completing cycle.
  - 0x0C up to 4*(NUM_REGS-1): scratch, read/write.
- The FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSELx=1 and PENABLE=0.
  - SETUP -> ACCESS unconditionally. The wait counter loads WAIT_STATES, and the decode result (index, error) and PWRITE are registered here.
  - ACCESS holds while the counter is non-zero, decrementing once per cycle.
  - When the counter is 0, the transfer completes. The next state is SETUP if PSELx=1 and PENABLE=0 in the following cycle's inputs; otherwise IDLE. Back-to-back transfers lose no cycle.
- Error decode: PSLVERR=1 if any of the following holds:
  - PADDR[1:0] != 0;
  - PADDR[31:2] >= NUM_REGS;
  - a write to ID or STATUS;
  - a read with PSTRB != 0;
  - PNSE=1;
  - a write to CTRL with PPROT[0]=0 (unprivileged).
- An errored write modifies no register. An errored read returns PRDATA=0.
- Write commit happens on the completing cycle, for each byte lane i with PSTRB[i]=1. A write with PSTRB=0 is legal, changes nothing and returns PSLVERR=0.
- proto_err pulses for one cycle on any of:
  - PENABLE=1 while in IDLE;
  - PSELx=0 or PENABLE=0 while in ACCESS.
- On a violation in ACCESS, the FSM aborts to IDLE with no write commit and PREADY stays 0.

## Timing
- Reset: PRESET=1 at a rising edge forces, on that same edge:
  - state IDLE and counter 0;
  - PRDATA=0, PREADY=0, PSLVERR=0, proto_err=0;
  - CTRL=CTRL_RST and scratch registers = 0.
- Reset mid-transfer discards the pending write; no PREADY is issued.
- PREADY is 1 only in ACCESS with counter = 0; it is 0 in every other state.
- PSLVERR and PRDATA are qualified by PREADY and are 0 whenever PREADY=0.
- Latency from the SETUP cycle to PREADY is WAIT_STATES+1 cycles. With WAIT_STATES=0, a transfer occupies exactly 2 cycles.
- Read data reflects any write that completed in an earlier cycle.
- ctrl_out updates on the edge that ends the completing write cycle.
- PADDR, PWRITE, PWDATA and PSTRB are used as registered in SETUP; changes during ACCESS are ignored. PWDATA is sampled in SETUP.

## Test plan
- Reset, then read 0x00 with WAIT_STATES=1 -> PREADY rises on the 3rd cycle after SETUP entry; PRDATA=32'hA5B0_0001; PSLVERR=0.
- Write 0x04 = 32'h1234_5678 with PSTRB=4'b0101 and PPROT=3'b001 over CTRL=0 -> ctrl_out=32'h0034_0078; a read of 0x04 returns the same value.
- Write 0x08, read 0x06 (misaligned), and read 0x20 with NUM_REGS=8 -> each gets PSLVERR=1 on its PREADY cycle; the registers are unchanged; the errored reads return PRDATA=0.
- Back-to-back write 0x0C = 32'hDEAD_BEEF followed immediately by a read of 0x0C, WAIT_STATES=0 -> 4 cycles total; the read returns 32'hDEAD_BEEF.
- Drop PENABLE mid-ACCESS with WAIT_STATES=3 -> proto_err pulses for 1 cycle; no PREADY; the target register is unchanged.
- Assert PRESET during ACCESS of a write to CTRL -> no PREADY; ctrl_out=CTRL_RST; all outputs are 0 on the next cycle.
